// File: rtl/cpu_pkg.sv
// Shared types for the control sequencer: instruction classes, FSM states,
// HALT encoding and the registered control bundle.
package cpu_pkg;

  typedef enum logic [1:0] {
    TYPE_R  = 2'b00,
    TYPE_BR = 2'b01,
    TYPE_I  = 2'b10,
    TYPE_LS = 2'b11
  } instr_type_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALTED   = 2'b10
  } seq_state_e;

  // HALT is the branch type code followed by an all-zero remainder.
  localparam instr_type_e HALT_TYPE = TYPE_BR;

  typedef struct packed {
    logic branch_en;
    logic write_en;
    logic mem_read;
    logic mem_write;
    logic use_immediate;
    logic write_reg_en;
    logic special_en;
  } ctrl_bundle_t;

  localparam int CTRL_W = $bits(ctrl_bundle_t);
  localparam ctrl_bundle_t CTRL_NONE = '0;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational instruction decoder: maps one instruction word to the
// control bundle plus HALT and load/store flags used by the sequencer FSM.
module ctrl_decode_comb
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 9
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic               is_halt,
  output logic               is_mem
);

  instr_type_e  itype;
  logic         move_hit;
  ctrl_bundle_t bundle;

  always_comb begin
    itype    = instr_type_e'(instr[INSTR_W-1:INSTR_W-2]);
    bundle   = CTRL_NONE;
    is_halt  = 1'b0;
    is_mem   = 1'b0;
    // A move is an R-type with a zero upper field and dst code above src code.
    move_hit = (instr[INSTR_W-3:5] == '0) && (instr[3:2] > instr[1:0]);

    case (itype)
      TYPE_R: begin
        bundle.write_en = 1'b1;
        if (move_hit) begin
          bundle.write_reg_en = 1'b1;
          bundle.special_en   = 1'b1;
        end
      end
      TYPE_BR: begin
        if ((itype == HALT_TYPE) && (instr[INSTR_W-3:0] == '0)) begin
          is_halt = 1'b1;
        end else begin
          bundle.branch_en = 1'b1;
        end
      end
      TYPE_I: begin
        bundle.write_en      = 1'b1;
        bundle.use_immediate = 1'b1;
      end
      TYPE_LS: begin
        is_mem = 1'b1;
        if (instr[INSTR_W-3]) begin
          bundle.mem_write = 1'b1;
        end else begin
          bundle.mem_read     = 1'b1;
          bundle.write_en     = 1'b1;
          bundle.write_reg_en = 1'b1;
        end
      end
      default: begin
        bundle = CTRL_NONE;
      end
    endcase

    ctrl_o = bundle;
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction sequencer: accepts one decoded instruction per RUN cycle,
// registers its control bundle, stalls MEM_LAT cycles after loads/stores and
// parks in HALTED after a HALT until reset.
module ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 9,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic               flush,
  output logic               instr_ready,
  output logic               ctrl_valid,
  output logic               branch_en,
  output logic               write_en,
  output logic               mem_read,
  output logic               mem_write,
  output logic               use_immediate,
  output logic               write_reg_en,
  output logic               special_en,
  output logic               done
);

  localparam int               CNT_W    = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  ctrl_bundle_t      ctrl_q, ctrl_d;

  logic [CTRL_W-1:0] dec_bits;
  ctrl_bundle_t      dec_bundle;
  logic              dec_halt;
  logic              dec_mem;
  logic              accept;

  ctrl_decode_comb #(
    .INSTR_W (INSTR_W)
  ) u_decode (
    .instr   (instr),
    .ctrl_o  (dec_bits),
    .is_halt (dec_halt),
    .is_mem  (dec_mem)
  );

  assign dec_bundle  = ctrl_bundle_t'(dec_bits);
  assign instr_ready = (state_q == ST_RUN);
  assign accept      = instr_valid && instr_ready && !flush;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ctrl_valid_d = 1'b0;
    ctrl_d       = CTRL_NONE;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (dec_halt) begin
            state_d = ST_HALTED;
          end else begin
            ctrl_valid_d = 1'b1;
            ctrl_d       = dec_bundle;
            if (dec_mem && (MEM_LAT > 0)) begin
              state_d = ST_MEM_WAIT;
              cnt_d   = CNT_LOAD;
            end
          end
        end
      end
      ST_MEM_WAIT: begin
        // Flush is deliberately ignored here: the memory op is committed.
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      ctrl_valid_q <= 1'b0;
      ctrl_q       <= CTRL_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctrl_valid_q <= ctrl_valid_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign ctrl_valid    = ctrl_valid_q;
  assign branch_en     = ctrl_q.branch_en;
  assign write_en      = ctrl_q.write_en;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign use_immediate = ctrl_q.use_immediate;
  assign write_reg_en  = ctrl_q.write_reg_en;
  assign special_en    = ctrl_q.special_en;
  assign done          = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: two instances (MEM_LAT=2 and MEM_LAT=0) share
// stimulus; directed scenarios plus random traffic against a reference model.
module tb_ctrl_sequencer;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         instr_valid = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] instr = '0;

  logic rdy2, cv2, br2, we2, mr2, mw2, imm2, wr2, sp2, done2;
  logic rdy0, cv0, br0, we0, mr0, mw0, imm0, wr0, sp0, done0;
  logic [6:0] f2, f0;

  ctrl_sequencer #(.INSTR_W(W), .MEM_LAT(2)) dut_lat2 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .flush(flush),
    .instr_ready(rdy2), .ctrl_valid(cv2), .branch_en(br2), .write_en(we2),
    .mem_read(mr2), .mem_write(mw2), .use_immediate(imm2), .write_reg_en(wr2),
    .special_en(sp2), .done(done2)
  );

  ctrl_sequencer #(.INSTR_W(W), .MEM_LAT(0)) dut_lat0 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .flush(flush),
    .instr_ready(rdy0), .ctrl_valid(cv0), .branch_en(br0), .write_en(we0),
    .mem_read(mr0), .mem_write(mw0), .use_immediate(imm0), .write_reg_en(wr0),
    .special_en(sp0), .done(done0)
  );

  always #5 clk = ~clk;

  // Field order: branch, write, mem_read, mem_write, imm, write_reg, special
  assign f2 = {br2, we2, mr2, mw2, imm2, wr2, sp2};
  assign f0 = {br0, we0, mr0, mw0, imm0, wr0, sp0};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, index 0 -> MEM_LAT=2 instance, 1 -> MEM_LAT=0.
  int         lat[2] = '{2, 0};
  int         stall[2];
  bit         halted[2];
  bit         exp_v[2];
  logic [6:0] exp_f[2];

  function automatic bit ref_is_halt(logic [8:0] w);
    return w == 9'b010000000;
  endfunction

  function automatic bit ref_is_mem(logic [8:0] w);
    return w[8:7] == 2'b11;
  endfunction

  function automatic logic [6:0] ref_fields(logic [8:0] w);
    logic [1:0] t;
    t = w[8:7];
    if (t == 2'b00) begin
      if (w[6:5] == 2'b00 && w[3:2] > w[1:0]) return 7'b0100011;
      return 7'b0100000;
    end
    if (t == 2'b01) return 7'b1000000;
    if (t == 2'b10) return 7'b0100100;
    if (w[6]) return 7'b0001000;
    return 7'b0110010;
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        stall[k] = 0; halted[k] = 0; exp_v[k] = 0; exp_f[k] = '0;
      end else if (!halted[k] && stall[k] == 0 && instr_valid && !flush) begin
        if (ref_is_halt(instr)) begin
          halted[k] = 1; exp_v[k] = 0; exp_f[k] = '0;
        end else begin
          exp_v[k] = 1; exp_f[k] = ref_fields(instr);
          if (ref_is_mem(instr)) stall[k] = lat[k];
        end
      end else begin
        exp_v[k] = 0; exp_f[k] = '0;
        if (stall[k] > 0) stall[k]--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; instr_valid = 0; flush = 0; instr = '0;
    tick(); tick();
    n_cmp++;
    if ({rdy2, cv2, done2, f2} !== {1'b1, 1'b0, 1'b0, 7'b0}) begin
      n_err++; $display("FAIL reset_lat2 got %b want %b", {rdy2, cv2, done2, f2}, 10'b1000000000);
    end
    n_cmp++;
    if ({rdy0, cv0, done0, f0} !== {1'b1, 1'b0, 1'b0, 7'b0}) begin
      n_err++; $display("FAIL reset_lat0 got %b want %b", {rdy0, cv0, done0, f0}, 10'b1000000000);
    end
    reset = 0;
    n_cmp++;
    if (rdy2 !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready got %b want 1", rdy2);
    end
  endtask

  task automatic test_back_to_back();
    instr_valid = 1; instr = 9'b000100110;
    tick();
    n_cmp++;
    if ({cv2, f2, rdy2} !== {1'b1, 7'b0100000, 1'b1}) begin
      n_err++; $display("FAIL b2b_first got %b want %b", {cv2, f2, rdy2}, 9'b101000001);
    end
    instr = 9'b101000011;
    tick();
    n_cmp++;
    if ({cv2, f2, rdy2} !== {1'b1, 7'b0100100, 1'b1}) begin
      n_err++; $display("FAIL b2b_second got %b want %b", {cv2, f2, rdy2}, 9'b101001001);
    end
    instr_valid = 0;
    tick();
    n_cmp++;
    if ({cv2, f2} !== 8'b0) begin
      n_err++; $display("FAIL b2b_idle got %b want 00000000", {cv2, f2});
    end
  endtask

  task automatic test_load_stall();
    instr_valid = 1; instr = 9'b110000001;
    tick();
    n_cmp++;
    if ({cv2, f2, rdy2} !== {1'b1, 7'b0110010, 1'b0}) begin
      n_err++; $display("FAIL load_n1_lat2 got %b want %b", {cv2, f2, rdy2}, 9'b101100100);
    end
    n_cmp++;
    if ({cv0, f0, rdy0} !== {1'b1, 7'b0110010, 1'b1}) begin
      n_err++; $display("FAIL load_n1_lat0 got %b want %b", {cv0, f0, rdy0}, 9'b101100101);
    end
    instr_valid = 0;
    tick();
    n_cmp++;
    if ({cv2, f2, rdy2} !== 9'b0) begin
      n_err++; $display("FAIL load_n2_lat2 got %b want 000000000", {cv2, f2, rdy2});
    end
    tick();
    n_cmp++;
    if (rdy2 !== 1'b1) begin
      n_err++; $display("FAIL load_n3_ready got %b want 1", rdy2);
    end
  endtask

  task automatic test_move();
    instr_valid = 1; instr = 9'b000001101;
    tick();
    n_cmp++;
    if ({cv2, f2} !== {1'b1, 7'b0100011}) begin
      n_err++; $display("FAIL move_decode got %b want %b", {cv2, f2}, 8'b10100011);
    end
    instr = 9'b000000001;
    tick();
    n_cmp++;
    if ({cv2, f2} !== {1'b1, 7'b0100000}) begin
      n_err++; $display("FAIL nonmove_decode got %b want %b", {cv2, f2}, 8'b10100000);
    end
    instr_valid = 0;
    tick();
  endtask

  task automatic test_flush();
    instr_valid = 1; flush = 1; instr = 9'b010000101;
    tick();
    n_cmp++;
    if ({cv2, f2, rdy2, done2} !== {1'b0, 7'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL flush_kill got %b want %b", {cv2, f2, rdy2, done2}, 10'b0000000010);
    end
    flush = 0;
    tick();
    n_cmp++;
    if ({cv2, f2} !== {1'b1, 7'b1000000}) begin
      n_err++; $display("FAIL branch_after_flush got %b want %b", {cv2, f2}, 8'b11000000);
    end
    instr_valid = 0;
    tick();
  endtask

  task automatic test_halt();
    instr_valid = 1; instr = 9'b010000000;
    tick();
    n_cmp++;
    if ({done2, rdy2, cv2, done0, rdy0} !== 5'b10010) begin
      n_err++; $display("FAIL halt_enter got %b want 10010", {done2, rdy2, cv2, done0, rdy0});
    end
    for (int i = 0; i < 20; i++) begin
      instr_valid = 1'($urandom);
      flush = 1'($urandom);
      instr = 9'($urandom);
      tick();
      n_cmp++;
      if ({done2, rdy2, cv2, f2} !== {1'b1, 1'b0, 1'b0, 7'b0}) begin
        n_err++; $display("FAIL halt_hold cycle %0d got %b want 1000000000", i, {done2, rdy2, cv2, f2});
      end
    end
    reset = 1; instr_valid = 0; flush = 0;
    tick();
    reset = 0;
    n_cmp++;
    if ({done2, rdy2} !== 2'b01) begin
      n_err++; $display("FAIL halt_reset got %b want 01", {done2, rdy2});
    end
  endtask

  task automatic test_reset_mid_stall();
    instr_valid = 1; instr = 9'b110000001;
    tick();
    n_cmp++;
    if ({rdy2, rdy0} !== 2'b01) begin
      n_err++; $display("FAIL midstall_enter got %b want 01", {rdy2, rdy0});
    end
    instr_valid = 0; reset = 1;
    tick();
    reset = 0;
    n_cmp++;
    if ({rdy2, cv2, done2, f2} !== {1'b1, 1'b0, 1'b0, 7'b0}) begin
      n_err++; $display("FAIL midstall_reset got %b want 1000000000", {rdy2, cv2, done2, f2});
    end
    instr_valid = 1; instr = 9'b111000000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({cv0, f0, rdy0} !== {1'b1, 7'b0001000, 1'b1}) begin
        n_err++; $display("FAIL lat0_store_b2b beat %0d got %b want 100010001", i, {cv0, f0, rdy0});
      end
    end
    instr_valid = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_random();
    logic [9:0] act, want;
    int r;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(99) < 2) ||
              ((halted[0] || halted[1]) && $urandom_range(9) == 0);
      r = $urandom_range(99);
      if (r < 4)       instr = 9'b010000000;
      else if (r < 20) instr = {4'b0000, 1'($urandom), 4'($urandom)};
      else             instr = 9'($urandom);
      instr_valid = ($urandom_range(3) != 0);
      flush = ($urandom_range(9) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        act  = (k == 0) ? {rdy2, cv2, done2, f2} : {rdy0, cv0, done0, f0};
        want = {(!halted[k] && stall[k] == 0), exp_v[k], halted[k], exp_f[k]};
        n_cmp++;
        if (act !== want) begin
          n_err++;
          $display("FAIL random cyc %0d lat %0d got %b want %b", c, lat[k], act, want);
        end
      end
    end
    reset = 0; instr_valid = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_stall();
    test_move();
    test_flush();
    test_halt();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
